// File: rtl/risc_issue_ctrl_if.sv
// Bundle of fetch, writeback, data-memory and debug signals around the
// issue/hazard controller. Master drives the stimulus side; slave is the
// controller itself.
interface risc_issue_ctrl_if;
  logic        if_valid;
  logic [12:0] if_instr;
  logic        wb_valid;
  logic [2:0]  wb_dst;
  logic        dm_ack;
  logic        issue;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_addr;
  logic        dm_err;
  logic        mem_busy;
  logic [7:0]  pending;

  modport master (
    output if_valid, if_instr, wb_valid, wb_dst, dm_ack,
    input  issue, stall, dm_req, dm_we, dm_addr, dm_err, mem_busy, pending
  );

  modport slave (
    input  if_valid, if_instr, wb_valid, wb_dst, dm_ack,
    output issue, stall, dm_req, dm_we, dm_addr, dm_err, mem_busy, pending
  );
endinterface

// File: rtl/risc_issue_ctrl.sv
// Issue/hazard controller for the 13-bit RISC pipeline: 8-entry register
// scoreboard with RAW/WAW stalls, plus a two-state sequencer for the
// single-port data memory (req/ack handshake with timeout abort).
module risc_issue_ctrl #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst_n,
  risc_issue_ctrl_if.slave bus
);

  typedef enum logic {IDLE, MEM} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [7:0] onehot(input logic [2:0] r);
    logic [7:0] m;
    m    = 8'h00;
    m[r] = 1'b1;
    return m;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             we_q;
  logic [3:0]       addr_q;
  logic             mem_ld_q;
  logic [2:0]       mem_dst_q;
  logic [7:0]       pending_q, pending_d;

  logic [3:0] opcode;
  logic       is_ld, is_st, has_dst;
  logic [7:0] src_mask, dst_mask;
  logic [3:0] mem_addr;
  logic [7:0] wb_mask, eff, to_clr;
  logic       hazard, issue_c;

  assign opcode = bus.if_instr[12:9];
  assign is_ld  = (opcode == 4'b1110);
  assign is_st  = (opcode == 4'b1111);

  // Field decode: source/destination masks and memory address per opcode class
  always_comb begin
    src_mask = 8'h00;
    dst_mask = 8'h00;
    has_dst  = 1'b0;
    mem_addr = 4'h0;
    if (is_ld) begin
      dst_mask = onehot(bus.if_instr[2:0]);
      has_dst  = 1'b1;
      mem_addr = bus.if_instr[7:4];
    end else if (is_st) begin
      src_mask = onehot(bus.if_instr[6:4]);
      mem_addr = bus.if_instr[3:0];
    end else begin
      src_mask = onehot(bus.if_instr[8:6]) | onehot(bus.if_instr[5:3]);
      dst_mask = onehot(bus.if_instr[2:0]);
      has_dst  = 1'b1;
    end
  end

  // A same-cycle writeback releases its register before the hazard check
  assign wb_mask = bus.wb_valid ? onehot(bus.wb_dst) : 8'h00;
  assign eff     = pending_q & ~wb_mask;
  assign hazard  = |(eff & (src_mask | dst_mask));

  // issue/stall are gated by rst_n so both read 0 throughout reset
  assign issue_c   = rst_n & bus.if_valid & ~hazard & (state_q == IDLE);
  assign bus.issue = issue_c;
  assign bus.stall = rst_n & bus.if_valid & ~issue_c;

  // Next-state logic for the memory sequencer, wait counter and timeout effects
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    to_clr  = 8'h00;
    case (state_q)
      IDLE: begin
        if (issue_c && (is_ld || is_st)) begin
          state_d = MEM;
          cnt_d   = '0;
        end
      end
      MEM: begin
        if (bus.dm_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Aborted load never writes back, so release its destination here
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (mem_ld_q) to_clr = onehot(mem_dst_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard: clears first, then the issued destination is set (set wins)
  always_comb begin
    pending_d = pending_q & ~wb_mask & ~to_clr;
    if (issue_c && has_dst) pending_d = pending_d | dst_mask;
  end

  // Sequencer state, counter, error pulse and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pending_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
  end

  // Latch access attributes when a ld/st issues; they stay stable through MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= 4'h0;
      mem_ld_q  <= 1'b0;
      mem_dst_q <= 3'd0;
    end else if (state_q == IDLE && issue_c && (is_ld || is_st)) begin
      we_q      <= is_st;
      addr_q    <= mem_addr;
      mem_ld_q  <= is_ld;
      mem_dst_q <= bus.if_instr[2:0];
    end
  end

  assign bus.dm_req   = (state_q == MEM);
  assign bus.dm_we    = we_q;
  assign bus.dm_addr  = addr_q;
  assign bus.dm_err   = err_q;
  assign bus.mem_busy = (state_q == MEM);
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_risc_issue_ctrl.sv
// Directed bench for risc_issue_ctrl: scoreboard hazards, ld/st handshake,
// timeout abort, same-cycle set/clear and asynchronous reset in MEM.
module tb_risc_issue_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;

  risc_issue_ctrl_if bus ();

  risc_issue_ctrl #(.TIMEOUT_CYC(15), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] alu(input logic [3:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] d);
    return {op, a, b, d};
  endfunction

  function automatic logic [12:0] ld(input logic [3:0] addr, input logic [2:0] d);
    return {4'b1110, 1'b0, addr, 1'b0, d};
  endfunction

  function automatic logic [12:0] st(input logic [2:0] src, input logic [3:0] addr);
    return {4'b1111, 2'b00, src, addr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_req_drop(output int cycles);
    cycles = 0;
    while (bus.dm_req === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = alu(4'b0001, 3'd1, 3'd2, 3'd3);
    bus.wb_valid = 1'b0;
    bus.wb_dst   = 3'd0;
    bus.dm_ack   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_dm_req", bus.dm_req, 1'b0);
    chk("rst_dm_we", bus.dm_we, 1'b0);
    chk("rst_dm_addr", bus.dm_addr, 4'h0);
    chk("rst_dm_err", bus.dm_err, 1'b0);
    chk("rst_mem_busy", bus.mem_busy, 1'b0);
    chk("rst_issue", bus.issue, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);

    // First issue: ADD R1,R2->R3
    rst_n = 1'b1;
    settle();
    chk("add_issue", bus.issue, 1'b1);
    chk("add_stall", bus.stall, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    settle();
    chk("add_pending", bus.pending, 8'h08);

    // RAW on R3: SUB R3,R0->R7 stalls until R3 writes back
    bus.if_valid = 1'b1;
    bus.if_instr = alu(4'b0010, 3'd3, 3'd0, 3'd7);
    settle();
    chk("raw_stall", bus.stall, 1'b1);
    chk("raw_issue", bus.issue, 1'b0);
    tick();
    chk("raw_hold_stall", bus.stall, 1'b1);
    chk("raw_hold_pending", bus.pending, 8'h08);
    bus.wb_valid = 1'b1;
    bus.wb_dst   = 3'd3;
    settle();
    chk("raw_wb_issue", bus.issue, 1'b1);
    chk("raw_wb_stall", bus.stall, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    bus.wb_dst   = 3'd7;
    settle();
    chk("raw_pending", bus.pending, 8'h80);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("wb_clear_pending", bus.pending, 8'h00);

    // Load R5 from 0xA, ack in third MEM cycle
    bus.if_valid = 1'b1;
    bus.if_instr = ld(4'hA, 3'd5);
    settle();
    chk("ld_issue", bus.issue, 1'b1);
    tick();
    bus.if_instr = alu(4'b0001, 3'd0, 3'd1, 3'd2);
    settle();
    chk("ld_dm_req", bus.dm_req, 1'b1);
    chk("ld_dm_we", bus.dm_we, 1'b0);
    chk("ld_dm_addr", bus.dm_addr, 4'hA);
    chk("ld_pending", bus.pending, 8'h20);
    chk("ld_mem_busy", bus.mem_busy, 1'b1);
    chk("mem_no_issue", bus.issue, 1'b0);
    chk("mem_stall", bus.stall, 1'b1);
    tick();
    chk("ld_req_stable", bus.dm_req, 1'b1);
    chk("ld_addr_stable", bus.dm_addr, 4'hA);
    tick();
    bus.dm_ack = 1'b1;
    tick();
    bus.dm_ack = 1'b0;
    settle();
    chk("ld_ack_req", bus.dm_req, 1'b0);
    chk("ld_ack_busy", bus.mem_busy, 1'b0);
    chk("ld_ack_pending", bus.pending, 8'h20);
    chk("ld_ack_err", bus.dm_err, 1'b0);
    chk("post_ack_issue", bus.issue, 1'b1);
    tick();
    bus.if_valid = 1'b0;
    settle();
    chk("post_ack_pending", bus.pending, 8'h24);

    // Store from R6 to 0x3 with no ack: timeout after 15 cycles
    bus.if_valid = 1'b1;
    bus.if_instr = st(3'd6, 4'h3);
    settle();
    chk("st_issue", bus.issue, 1'b1);
    tick();
    bus.if_valid = 1'b0;
    settle();
    chk("st_dm_we", bus.dm_we, 1'b1);
    chk("st_dm_addr", bus.dm_addr, 4'h3);
    wait_req_drop(n);
    chk("st_req_cycles", n, 15);
    chk("st_to_err", bus.dm_err, 1'b1);
    chk("st_to_busy", bus.mem_busy, 1'b0);
    chk("st_to_pending", bus.pending, 8'h24);
    tick();
    chk("st_err_pulse", bus.dm_err, 1'b0);

    // Load timeout releases its destination R1
    bus.if_valid = 1'b1;
    bus.if_instr = ld(4'h7, 3'd1);
    settle();
    chk("ld2_issue", bus.issue, 1'b1);
    tick();
    bus.if_valid = 1'b0;
    settle();
    chk("ld2_pending", bus.pending, 8'h26);
    wait_req_drop(n);
    chk("ld2_req_cycles", n, 15);
    chk("ld2_to_err", bus.dm_err, 1'b1);
    chk("ld2_to_pending", bus.pending, 8'h24);
    tick();

    // Ack in the last allowed cycle beats the timeout
    bus.if_valid = 1'b1;
    bus.if_instr = ld(4'h9, 3'd0);
    settle();
    chk("ld3_issue", bus.issue, 1'b1);
    tick();
    bus.if_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("ld3_req_last", bus.dm_req, 1'b1);
    bus.dm_ack = 1'b1;
    tick();
    bus.dm_ack = 1'b0;
    settle();
    chk("ld3_ack_err", bus.dm_err, 1'b0);
    chk("ld3_ack_req", bus.dm_req, 1'b0);
    chk("ld3_ack_pending", bus.pending, 8'h25);

    // Same-cycle writeback and reissue of R4: set wins
    bus.if_valid = 1'b1;
    bus.if_instr = alu(4'b0011, 3'd6, 3'd7, 3'd4);
    settle();
    chk("r4_issue", bus.issue, 1'b1);
    tick();
    settle();
    chk("r4_pending", bus.pending, 8'h35);
    chk("r4_waw_stall", bus.stall, 1'b1);
    bus.wb_valid = 1'b1;
    bus.wb_dst   = 3'd4;
    settle();
    chk("setclr_issue", bus.issue, 1'b1);
    tick();
    bus.wb_valid = 1'b0;
    bus.if_valid = 1'b0;
    settle();
    chk("setclr_pending", bus.pending, 8'h35);

    // Fill scoreboard to 8'hFF, then async reset while in MEM
    bus.if_valid = 1'b1;
    bus.if_instr = alu(4'b0001, 3'd1, 3'd1, 3'd1);
    tick();
    bus.if_instr = alu(4'b0001, 3'd3, 3'd3, 3'd3);
    tick();
    bus.if_instr = alu(4'b0001, 3'd6, 3'd6, 3'd6);
    tick();
    bus.if_instr = ld(4'hB, 3'd7);
    tick();
    bus.if_valid = 1'b0;
    settle();
    chk("full_pending", bus.pending, 8'hFF);
    chk("full_dm_req", bus.dm_req, 1'b1);
    chk("full_dm_addr", bus.dm_addr, 4'hB);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dm_req", bus.dm_req, 1'b0);
    chk("arst_pending", bus.pending, 8'h00);
    chk("arst_dm_err", bus.dm_err, 1'b0);
    chk("arst_busy", bus.mem_busy, 1'b0);
    tick();
    tick();
    chk("arst_err_hold", bus.dm_err, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_err", bus.dm_err, 1'b0);
    chk("post_rst_req", bus.dm_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_issue_ctrl.md
Name: risc_issue_ctrl

Overview:
- Issue/hazard controller between instruction fetch and the decode register stage of the 13-bit RISC pipeline.
- Holds an 8-entry register scoreboard and stalls fetch/decode on RAW/WAW hazards.
- Sequences the single-port data memory for ld/st with a req/ack handshake and a timeout.
- Reports hazard and memory status for debug.

Parameters:
TIMEOUT_CYC, 15, max cycles in MEM waiting for dm_ack before abort (1..255)
CNT_W, 8, width of memory wait counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_valid  in  1  fetched instruction presented this cycle
if_instr  in  13  fetched instruction; opcode = [12:9]
wb_valid  in  1  writeback completes this cycle
wb_dst  in  3  register written back
dm_ack  in  1  data memory completes current access
issue  out  1  instruction accepted into decode this cycle
stall  out  1  hold fetch and decode registers
dm_req  out  1  data memory request
dm_we  out  1  1=store, 0=load
dm_addr  out  4  data memory address
dm_err  out  1  one-cycle pulse on memory timeout
mem_busy  out  1  FSM in MEM
pending  out  8  scoreboard, bit r = write to Rr outstanding

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. During and after reset: pending=0, FSM=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_err=0, wait counter=0. issue=stall=0 while rst_n low.
- Field decode, all on if_instr:
  - ld (1110): no register sources; dst=[2:0]; mem address=[7:4].
  - st (1111): source=[6:4]; no dst; mem address=[3:0].
  - All other opcodes: sources=[8:6] and [5:3]; dst=[2:0].
- Effective pending: eff = pending & ~(wb_valid ? onehot(wb_dst) : 0). A same-cycle writeback releases the register.
- hazard = any used source bit set in eff, OR dst bit set in eff (WAW).
- issue = if_valid & ~hazard & (FSM==IDLE), combinational.
- stall = if_valid & ~issue, combinational.
- Scoreboard update at each posedge:
  - Clear bit wb_dst if wb_valid.
  - Then set bit dst if issue and the opcode has a dst.
  - Set wins when both hit the same register.
  - wb_valid on a non-pending bit is harmless.
- FSM states IDLE and MEM:
  - IDLE to MEM: issue of ld/st. Next cycle: dm_req=1, dm_we=(st), dm_addr=latched address. Latency issue->dm_req is 1 cycle.
  - MEM: dm_req, dm_we and dm_addr stay stable; issue=0. Counter increments each MEM cycle, starting at 0.
  - MEM to IDLE on dm_ack=1 sampled at the edge: dm_req=0 from the following cycle, and issue is possible in that cycle.
  - MEM to IDLE on timeout, i.e. counter reaches TIMEOUT_CYC-1 with no ack: dm_err=1 for exactly one cycle, dm_req drops, and for a ld the pending bit of its dst is cleared. Ack takes priority over timeout in the same cycle.
  - dm_ack in IDLE is ignored.
- mem_busy = (FSM==MEM).
- A non-memory instruction issued in the same cycle as another is impossible: at most one issue per cycle.
- Reset mid-MEM: immediate IDLE, dm_req=0, scoreboard cleared, no dm_err.

Test Plan:
- Reset -> all outputs 0. Release with if_valid=1, if_instr=ADD R1,R2->R3 (opcode 0001, [8:6]=1, [5:3]=2, [2:0]=3) -> issue=1, next cycle pending=8'h08.
- RAW: pending=8'h08, present instr with source R3 -> stall=1, issue=0. Hold until wb_valid=1, wb_dst=3 -> issue=1 that same cycle, pending bit3 cleared.
- Load: issue ld, addr [7:4]=4'hA, dst R5 -> next cycle dm_req=1, dm_we=0, dm_addr=4'hA, pending[5]=1. dm_ack after 3 cycles -> dm_req=0 next cycle, pending[5] still 1.
- Store timeout: st, src R6 (not pending), addr 4'h3, no ack -> dm_req held 15 cycles, dm_err 1-cycle pulse, FSM IDLE, pending unchanged.
- Same-cycle set/clear: pending[4]=1, wb_valid wb_dst=4, issue instr with dst R4 and free sources -> issue=1, pending[4]=1 after edge.
- Async reset in MEM with pending=8'hFF -> dm_req=0 and pending=0 immediately, dm_err stays 0.
